// File: rtl/l1_cache_pkg.sv
// Shared encodings for the L1 data-cache controller: request opcodes and FSM states.
package l1_cache_pkg;

    localparam int unsigned CNT_W = 32;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_EVICT = 2'd3;

    typedef enum logic [2:0] {
        ST_CLEAR  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LOOKUP = 3'd2,
        ST_WB     = 3'd3,
        ST_FILL   = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

endpackage

// File: rtl/l1_lru_update.sv
// Age-based LRU update: the accessed way becomes age 0, ways younger than it age by one.
module l1_lru_update #(
    parameter int unsigned WAYS  = 4,
    parameter int unsigned AGE_W = 2
) (
    input  logic [WAYS*AGE_W-1:0] age_i,
    input  logic [AGE_W-1:0]      way_i,
    output logic [WAYS*AGE_W-1:0] age_o
);

    logic [AGE_W-1:0] acc_age;
    logic [AGE_W-1:0] cur_age;

    always_comb begin
        age_o   = age_i;
        acc_age = age_i[way_i*AGE_W +: AGE_W];
        cur_age = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            cur_age = age_i[w*AGE_W +: AGE_W];
            if (AGE_W'(w) == way_i) begin
                age_o[w*AGE_W +: AGE_W] = '0;
            end else if (cur_age < acc_age) begin
                age_o[w*AGE_W +: AGE_W] = cur_age + AGE_W'(1);
            end
        end
    end

endmodule

// File: rtl/l1_dcache_ctrl.sv
// L1 data-cache tag/state controller: lookup, LRU victim selection, L2 writeback/fill,
// evict handling, flash clear and saturating statistics.
module l1_dcache_ctrl
    import l1_cache_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned WAYS     = 4,
    parameter int unsigned INDEX_W  = 14,
    parameter int unsigned OFFSET_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic              l2_valid,
    input  logic              l2_ready,
    output logic              l2_we,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned AGE_W = $clog2(WAYS);
    localparam int unsigned SETS  = 1 << INDEX_W;

    // Per-set state arrays; the CLEAR walk initialises them, so no reset is needed.
    logic [WAYS-1:0]       valid_mem [SETS];
    logic [WAYS-1:0]       dirty_mem [SETS];
    logic [WAYS*AGE_W-1:0] age_mem   [SETS];
    logic [TAG_W-1:0]      tag_mem   [SETS][WAYS];

    state_e             state_q, state_d;
    logic [INDEX_W-1:0] clr_idx_q, clr_idx_d;
    logic [1:0]         op_q, op_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [INDEX_W-1:0] idx_q, idx_d;
    logic [AGE_W-1:0]   way_q, way_d;
    logic [TAG_W-1:0]   vtag_q, vtag_d;
    logic               hit_q, hit_d;

    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_hit_q, resp_hit_d;
    logic              l2_valid_q, l2_valid_d;
    logic              l2_we_q, l2_we_d;
    logic [ADDR_W-1:0] l2_addr_q, l2_addr_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

    logic [WAYS-1:0]       rd_valid, rd_dirty;
    logic [WAYS*AGE_W-1:0] rd_age, lru_age;
    logic [AGE_W-1:0]      lru_way, hit_way, vic_way;
    logic                  hit, inv_found;

    logic                  set_we, tag_we;
    logic [INDEX_W-1:0]    set_idx;
    logic [WAYS-1:0]       valid_wr, dirty_wr;
    logic [WAYS*AGE_W-1:0] age_wr;

    logic unused_offset;
    assign unused_offset = ^req_addr[OFFSET_W-1:0];

    assign rd_valid = valid_mem[idx_q];
    assign rd_dirty = dirty_mem[idx_q];
    assign rd_age   = age_mem[idx_q];
    assign lru_way  = (state_q == ST_FILL) ? way_q : hit_way;

    l1_lru_update #(.WAYS(WAYS), .AGE_W(AGE_W)) u_lru (
        .age_i (rd_age),
        .way_i (lru_way),
        .age_o (lru_age)
    );

    // Tag match and victim choice: lowest invalid way, else the oldest way.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        vic_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!hit && rd_valid[w] && (tag_mem[idx_q][w] == tag_q)) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
            if (!inv_found && !rd_valid[w]) begin
                inv_found = 1'b1;
                vic_way   = AGE_W'(w);
            end
        end
        if (!inv_found) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (rd_age[w*AGE_W +: AGE_W] == AGE_W'(WAYS - 1)) vic_way = AGE_W'(w);
            end
        end
    end

    // Next-state, array write port, counters and registered outputs.
    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        op_d       = op_q;
        tag_d      = tag_q;
        idx_d      = idx_q;
        way_d      = way_q;
        vtag_d     = vtag_q;
        hit_d      = hit_q;
        set_we     = 1'b0;
        tag_we     = 1'b0;
        set_idx    = idx_q;
        valid_wr   = rd_valid;
        dirty_wr   = rd_dirty;
        age_wr     = rd_age;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;

        case (state_q)
            ST_CLEAR: begin
                set_we    = 1'b1;
                set_idx   = clr_idx_q;
                valid_wr  = '0;
                dirty_wr  = '0;
                for (int unsigned w = 0; w < WAYS; w++) age_wr[w*AGE_W +: AGE_W] = AGE_W'(w);
                clr_idx_d = clr_idx_q + INDEX_W'(1);
                if (clr_idx_q == '1) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (clear) begin
                    state_d    = ST_CLEAR;
                    clr_idx_d  = '0;
                    hit_cnt_d  = '0;
                    miss_cnt_d = '0;
                    rd_cnt_d   = '0;
                    wr_cnt_d   = '0;
                end else if (req_valid) begin
                    op_d    = req_op;
                    tag_d   = req_addr[ADDR_W-1 -: TAG_W];
                    idx_d   = req_addr[OFFSET_W +: INDEX_W];
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if ((op_q == OP_READ) || (op_q == OP_WRITE)) begin
                    if (hit) begin
                        set_we = 1'b1;
                        age_wr = lru_age;
                        if (op_q == OP_WRITE) dirty_wr[hit_way] = 1'b1;
                        hit_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        way_d   = vic_way;
                        vtag_d  = tag_mem[idx_q][vic_way];
                        hit_d   = 1'b0;
                        state_d = (rd_valid[vic_way] && rd_dirty[vic_way]) ? ST_WB : ST_FILL;
                    end
                end else if ((op_q == OP_EVICT) && hit) begin
                    set_we            = 1'b1;
                    valid_wr[hit_way] = 1'b0;
                    dirty_wr[hit_way] = 1'b0;
                    way_d             = hit_way;
                    vtag_d            = tag_q;
                    hit_d             = 1'b1;
                    state_d           = rd_dirty[hit_way] ? ST_WB : ST_RESP;
                end else begin
                    hit_d   = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_WB: begin
                if (l2_ready) state_d = (op_q == OP_EVICT) ? ST_RESP : ST_FILL;
            end
            ST_FILL: begin
                if (l2_ready) begin
                    set_we          = 1'b1;
                    tag_we          = 1'b1;
                    valid_wr[way_q] = 1'b1;
                    dirty_wr[way_q] = (op_q == OP_WRITE);
                    age_wr          = lru_age;
                    state_d         = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if ((op_q == OP_READ) || (op_q == OP_WRITE)) begin
                    if (hit_q) hit_cnt_d  = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + CNT_W'(1);
                    else       miss_cnt_d = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + CNT_W'(1);
                    if (op_q == OP_READ) rd_cnt_d = (rd_cnt_q == '1) ? rd_cnt_q : rd_cnt_q + CNT_W'(1);
                    else                 wr_cnt_d = (wr_cnt_q == '1) ? wr_cnt_q : wr_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_CLEAR;
        endcase

        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
        resp_hit_d   = (state_d == ST_RESP) && hit_d;
        l2_valid_d   = (state_d == ST_WB) || (state_d == ST_FILL);
        l2_we_d      = (state_d == ST_WB);
        if (state_d == ST_WB)        l2_addr_d = {vtag_d, idx_d, {OFFSET_W{1'b0}}};
        else if (state_d == ST_FILL) l2_addr_d = {tag_d, idx_d, {OFFSET_W{1'b0}}};
        else                         l2_addr_d = '0;
    end

    always_ff @(posedge clk) begin
        if (set_we) begin
            valid_mem[set_idx] <= valid_wr;
            dirty_mem[set_idx] <= dirty_wr;
            age_mem[set_idx]   <= age_wr;
        end
        if (tag_we) tag_mem[idx_q][way_q] <= tag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            clr_idx_q    <= '0;
            op_q         <= '0;
            tag_q        <= '0;
            idx_q        <= '0;
            way_q        <= '0;
            vtag_q       <= '0;
            hit_q        <= 1'b0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            l2_valid_q   <= 1'b0;
            l2_we_q      <= 1'b0;
            l2_addr_q    <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            op_q         <= op_d;
            tag_q        <= tag_d;
            idx_q        <= idx_d;
            way_q        <= way_d;
            vtag_q       <= vtag_d;
            hit_q        <= hit_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            l2_valid_q   <= l2_valid_d;
            l2_we_q      <= l2_we_d;
            l2_addr_q    <= l2_addr_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_hit_q;
    assign l2_valid   = l2_valid_q;
    assign l2_we      = l2_we_q;
    assign l2_addr    = l2_addr_q;
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;
    assign rd_cnt     = rd_cnt_q;
    assign wr_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// Directed bench for l1_dcache_ctrl with a 2-way, 4-set cache and a scripted L2.
module tb_l1_dcache_ctrl;
    import l1_cache_pkg::*;

    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_op = 2'd0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              resp_valid, resp_hit;
    logic              l2_valid, l2_we;
    logic              l2_ready = 1'b1;
    logic [ADDR_W-1:0] l2_addr;
    logic [31:0]       hit_cnt, miss_cnt, rd_cnt, wr_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    logic        log_we [8];
    logic [31:0] log_addr [8];
    int          n_l2;
    int          lat;
    logic        got_hit;
    logic        resp_after;

    l1_dcache_ctrl #(.ADDR_W(32), .WAYS(2), .INDEX_W(2), .OFFSET_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_hit(resp_hit),
        .l2_valid(l2_valid), .l2_ready(l2_ready), .l2_we(l2_we), .l2_addr(l2_addr),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    // Issue one request at a negedge and record the L2 traffic and response it produces.
    task automatic issue(input logic [1:0] op, input logic [31:0] addr);
        int guard;
        n_l2 = 0; lat = -1; got_hit = 1'bx; resp_after = 1'bx; guard = 0;
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        req_valid = 1'b1; req_op = op; req_addr = addr;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (l2_valid && l2_ready && n_l2 < 8) begin
                log_we[n_l2] = l2_we; log_addr[n_l2] = l2_addr; n_l2++;
            end
            if (resp_valid) begin
                lat = c; got_hit = resp_hit;
                @(negedge clk);
                resp_after = resp_valid;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; l2_ready = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({req_ready, resp_valid, resp_hit, l2_valid, l2_we} !== 5'b0 || l2_addr !== 32'h0)
            begin tests_failed++; $display("FAIL reset_outputs: got rdy=%b rv=%b l2v=%b addr=%h, required all 0", req_ready, resp_valid, l2_valid, l2_addr); end
        tests_run++;
        if ((hit_cnt | miss_cnt | rd_cnt | wr_cnt) !== 32'h0)
            begin tests_failed++; $display("FAIL reset_counters: got %h %h %h %h, required 0", hit_cnt, miss_cnt, rd_cnt, wr_cnt); end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_walk_ready[%0d]: got %b required 0", i, req_ready); end
            @(negedge clk);
        end
        tests_run++;
        if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_rise: got %b required 1", req_ready); end
    endtask

    task automatic test_read_hit();
        issue(OP_READ, 32'h0000_0040);
        tests_run++;
        if (lat !== 3 || got_hit !== 1'b0 || resp_after !== 1'b0)
            begin tests_failed++; $display("FAIL read_miss_resp: got lat=%0d hit=%b after=%b, required 3 0 0", lat, got_hit, resp_after); end
        tests_run++;
        if (n_l2 !== 1 || log_we[0] !== 1'b0 || log_addr[0] !== 32'h40)
            begin tests_failed++; $display("FAIL read_miss_fill: got n=%0d we=%b addr=%h, required 1 0 00000040", n_l2, log_we[0], log_addr[0]); end
        issue(OP_READ, 32'h0000_0040);
        tests_run++;
        if (lat !== 2 || got_hit !== 1'b1 || n_l2 !== 0)
            begin tests_failed++; $display("FAIL read_hit: got lat=%0d hit=%b n=%0d, required 2 1 0", lat, got_hit, n_l2); end
        tests_run++;
        if (hit_cnt !== 32'd1 || miss_cnt !== 32'd1 || rd_cnt !== 32'd2 || wr_cnt !== 32'd0)
            begin tests_failed++; $display("FAIL read_counters: got h=%0d m=%0d r=%0d w=%0d, required 1 1 2 0", hit_cnt, miss_cnt, rd_cnt, wr_cnt); end
    endtask

    task automatic test_write_lru();
        issue(OP_WRITE, 32'h0000_0000);
        tests_run++;
        if (lat !== 3 || n_l2 !== 1 || log_we[0] !== 1'b0 || log_addr[0] !== 32'h000)
            begin tests_failed++; $display("FAIL write0_fill: got lat=%0d n=%0d we=%b addr=%h, required 3 1 0 0", lat, n_l2, log_we[0], log_addr[0]); end
        issue(OP_WRITE, 32'h0000_0100);
        tests_run++;
        if (lat !== 3 || n_l2 !== 1 || log_addr[0] !== 32'h100)
            begin tests_failed++; $display("FAIL write1_fill: got lat=%0d n=%0d addr=%h, required 3 1 100", lat, n_l2, log_addr[0]); end
        issue(OP_WRITE, 32'h0000_0200);
        tests_run++;
        if (lat !== 4 || got_hit !== 1'b0 || n_l2 !== 2)
            begin tests_failed++; $display("FAIL write2_resp: got lat=%0d hit=%b n=%0d, required 4 0 2", lat, got_hit, n_l2); end
        tests_run++;
        if (log_we[0] !== 1'b1 || log_addr[0] !== 32'h000 || log_we[1] !== 1'b0 || log_addr[1] !== 32'h200)
            begin tests_failed++; $display("FAIL write2_wb_fill: got %b/%h %b/%h, required 1/0 0/200", log_we[0], log_addr[0], log_we[1], log_addr[1]); end
        issue(OP_READ, 32'h0000_0100);
        tests_run++;
        if (lat !== 2 || got_hit !== 1'b1)
            begin tests_failed++; $display("FAIL lru_kept_mru: got lat=%0d hit=%b, required 2 1", lat, got_hit); end
        tests_run++;
        if (wr_cnt !== 32'd3 || rd_cnt !== 32'd3 || hit_cnt !== 32'd2 || miss_cnt !== 32'd4)
            begin tests_failed++; $display("FAIL write_counters: got w=%0d r=%0d h=%0d m=%0d, required 3 3 2 4", wr_cnt, rd_cnt, hit_cnt, miss_cnt); end
    endtask

    task automatic test_evict();
        issue(OP_EVICT, 32'h0000_0100);
        tests_run++;
        if (lat !== 3 || got_hit !== 1'b1 || n_l2 !== 1 || log_we[0] !== 1'b1 || log_addr[0] !== 32'h100)
            begin tests_failed++; $display("FAIL evict_dirty: got lat=%0d hit=%b n=%0d we=%b addr=%h, required 3 1 1 1 100", lat, got_hit, n_l2, log_we[0], log_addr[0]); end
        issue(OP_READ, 32'h0000_0100);
        tests_run++;
        if (got_hit !== 1'b0 || n_l2 !== 1 || log_we[0] !== 1'b0 || log_addr[0] !== 32'h100)
            begin tests_failed++; $display("FAIL read_after_evict: got hit=%b n=%0d we=%b addr=%h, required 0 1 0 100", got_hit, n_l2, log_we[0], log_addr[0]); end
        issue(2'd2, 32'h0000_0200);
        tests_run++;
        if (lat !== 2 || got_hit !== 1'b0 || n_l2 !== 0)
            begin tests_failed++; $display("FAIL illegal_op: got lat=%0d hit=%b n=%0d, required 2 0 0", lat, got_hit, n_l2); end
        issue(OP_READ, 32'h0000_0200);
        tests_run++;
        if (lat !== 2 || got_hit !== 1'b1)
            begin tests_failed++; $display("FAIL illegal_no_change: got lat=%0d hit=%b, required 2 1", lat, got_hit); end
        issue(OP_EVICT, 32'h0000_0100);
        tests_run++;
        if (lat !== 2 || got_hit !== 1'b1 || n_l2 !== 0)
            begin tests_failed++; $display("FAIL evict_clean: got lat=%0d hit=%b n=%0d, required 2 1 0", lat, got_hit, n_l2); end
        issue(OP_EVICT, 32'h0000_0300);
        tests_run++;
        if (lat !== 2 || got_hit !== 1'b0 || n_l2 !== 0)
            begin tests_failed++; $display("FAIL evict_miss: got lat=%0d hit=%b n=%0d, required 2 0 0", lat, got_hit, n_l2); end
        tests_run++;
        if (rd_cnt !== 32'd5 || wr_cnt !== 32'd3 || hit_cnt !== 32'd3 || miss_cnt !== 32'd5)
            begin tests_failed++; $display("FAIL evict_counters: got r=%0d w=%0d h=%0d m=%0d, required 5 3 3 5", rd_cnt, wr_cnt, hit_cnt, miss_cnt); end
    endtask

    task automatic test_clear_priority();
        int c;
        tests_run++;
        if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL clear_pre_ready: got %b required 1", req_ready); end
        clear = 1'b1; req_valid = 1'b1; req_op = OP_READ; req_addr = 32'h40;
        @(negedge clk);
        clear = 1'b0;
        tests_run++;
        if ((hit_cnt | miss_cnt | rd_cnt | wr_cnt) !== 32'h0)
            begin tests_failed++; $display("FAIL clear_counters: got %h %h %h %h, required 0", hit_cnt, miss_cnt, rd_cnt, wr_cnt); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (req_ready !== 1'b0 || resp_valid !== 1'b0)
                begin tests_failed++; $display("FAIL clear_walk[%0d]: got rdy=%b rv=%b, required 0 0", i, req_ready, resp_valid); end
            @(negedge clk);
        end
        tests_run++;
        if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL clear_ready_rise: got %b required 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        c = 0;
        while (!resp_valid && c < 20) begin @(negedge clk); c++; end
        tests_run++;
        if (resp_valid !== 1'b1 || resp_hit !== 1'b0 || c !== 2)
            begin tests_failed++; $display("FAIL clear_held_req: got rv=%b hit=%b wait=%0d, required 1 0 2", resp_valid, resp_hit, c); end
        @(negedge clk);
        tests_run++;
        if (rd_cnt !== 32'd1 || miss_cnt !== 32'd1 || hit_cnt !== 32'd0 || wr_cnt !== 32'd0)
            begin tests_failed++; $display("FAIL clear_after_counts: got r=%0d m=%0d h=%0d w=%0d, required 1 1 0 0", rd_cnt, miss_cnt, hit_cnt, wr_cnt); end
    endtask

    task automatic test_reset_mid_wb();
        logic saw_resp;
        int c;
        l2_ready = 1'b1;
        issue(OP_WRITE, 32'h0000_0000);
        issue(OP_WRITE, 32'h0000_0100);
        l2_ready = 1'b0;
        req_valid = 1'b1; req_op = OP_WRITE; req_addr = 32'h200;
        @(negedge clk);
        req_valid = 1'b0;
        c = 0;
        while (!l2_valid && c < 10) begin @(negedge clk); c++; end
        tests_run++;
        if (l2_valid !== 1'b1 || l2_we !== 1'b1 || l2_addr !== 32'h000)
            begin tests_failed++; $display("FAIL wb_request: got v=%b we=%b addr=%h, required 1 1 0", l2_valid, l2_we, l2_addr); end
        repeat (2) @(negedge clk);
        tests_run++;
        if (l2_valid !== 1'b1 || l2_we !== 1'b1 || l2_addr !== 32'h000)
            begin tests_failed++; $display("FAIL wb_stable: got v=%b we=%b addr=%h, required 1 1 0", l2_valid, l2_we, l2_addr); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (l2_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_drops_l2: got %b required 0", l2_valid); end
        saw_resp = 1'b0;
        repeat (2) begin @(negedge clk); if (resp_valid !== 1'b0) saw_resp = 1'b1; end
        l2_ready = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid !== 1'b0) saw_resp = 1'b1;
            tests_run++;
            if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL wb_reset_walk[%0d]: got %b required 0", i, req_ready); end
            @(negedge clk);
        end
        tests_run++;
        if (saw_resp !== 1'b0 || req_ready !== 1'b1)
            begin tests_failed++; $display("FAIL wb_reset_no_resp: got resp=%b rdy=%b, required 0 1", saw_resp, req_ready); end
        issue(OP_READ, 32'h0000_0000);
        tests_run++;
        if (got_hit !== 1'b0 || n_l2 !== 1 || log_we[0] !== 1'b0)
            begin tests_failed++; $display("FAIL post_reset_read: got hit=%b n=%0d we=%b, required 0 1 0", got_hit, n_l2, log_we[0]); end
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_write_lru();
        test_evict();
        test_clear_priority();
        test_reset_mid_wb();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/l1_dcache_ctrl.md
L1_DCACHE_CTRL -- requirements
Module: l1_dcache_ctrl

Interface
REQ-001 SHALL have these parameters:
- ADDR_W, default 32, address width.
- WAYS, default 4, associativity; power of two, at least 2.
- INDEX_W, default 14, set-index width.
- OFFSET_W, default 6, byte-select width.
- TAG_W, derived as ADDR_W-INDEX_W-OFFSET_W.
REQ-002 SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  pulse; flash-invalidate the cache and zero the statistics.
- req_valid  in  1  a request is offered.
- req_ready  out  1  the controller accepts a request this cycle.
- req_op  in  2  0 read, 1 write, 3 L2 evict; 2 is illegal.
- req_addr  in  ADDR_W  request address.
- resp_valid  out  1  one-cycle completion pulse.
- resp_hit  out  1  line was present; qualified by resp_valid.
- l2_valid  out  1  L2 transaction pending.
- l2_ready  in  1  L2 accepts and completes the transaction.
- l2_we  out  1  1 writeback, 0 fill read.
- l2_addr  out  ADDR_W  line address; offset bits are zero.
- hit_cnt, miss_cnt, rd_cnt, wr_cnt  out  32 each  statistics.

Function
REQ-003 Address split SHALL be tag = [ADDR_W-1 : INDEX_W+OFFSET_W], index = next INDEX_W bits, offset = low OFFSET_W bits (ignored).
REQ-004 Per set and way the controller SHALL store valid, dirty, TAG_W tag and a log2(WAYS)-bit age; the ages in a set are always a permutation of 0..WAYS-1.
REQ-005 FSM states SHALL be CLEAR, IDLE, LOOKUP, WB, FILL, RESP; req_ready=1 only in IDLE.
REQ-006 In IDLE, clear=1 SHALL go to CLEAR and takes priority: a simultaneous request is not accepted. Otherwise req_valid=1 SHALL latch op/address and go to LOOKUP.
REQ-007 In LOOKUP, a hit is a valid way with matching tag.
- Read or write hit: that way's age becomes 0; ways younger than its old age are incremented; a write sets dirty. Next state RESP with resp_hit=1, so resp_valid is high 2 cycles after acceptance.
REQ-008 Read or write miss, victim selection:
- Lowest-index invalid way; if none, the way with age WAYS-1.
- Dirty victim: go to WB.
- Clean victim: go to FILL.
REQ-009 WB SHALL hold l2_valid=1, l2_we=1, l2_addr = victim tag/index, until l2_ready=1, then go to FILL.
REQ-010 FILL SHALL hold l2_valid=1, l2_we=0, l2_addr = request line, until l2_ready=1. It then installs the tag, sets valid, sets dirty = (op==write), updates ages as on a hit, and goes to RESP with resp_hit=0.
REQ-011 Evict (op 3):
- Matching valid way: clear valid; if dirty, write back first via WB, then go to RESP with resp_hit=1; ages unchanged.
- No match: go to RESP with resp_hit=0.
REQ-012 Illegal op 2 SHALL complete as an evict miss with no state change.
REQ-013 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE.
REQ-014 Counters SHALL update at RESP and saturate at 2^32-1:
- rd_cnt on reads, wr_cnt on writes.
- hit_cnt and miss_cnt on reads and writes only; evicts do not count.
REQ-015 CLEAR SHALL walk index 0..2^INDEX_W-1, one set per cycle. Each set gets valid=0, dirty=0, age[w]=w. Counters are zeroed on entry. The last index moves to IDLE.
REQ-016 l2_valid, once high, SHALL hold l2_addr and l2_we stable until l2_ready.

Reset
REQ-017 rst_n low SHALL asynchronously force state CLEAR, clear index 0, all outputs 0 and counters 0.
REQ-018 Reset mid-transaction SHALL abandon the transaction: l2_valid drops immediately and no response is issued.
REQ-019 After release the controller SHALL complete a full CLEAR walk (2^INDEX_W cycles) before req_ready rises; tag and age arrays need no reset flops.

Structure
REQ-020 Package l1_cache_pkg SHALL hold the op encoding (OP_READ, OP_WRITE, OP_EVICT) and the FSM state enum.
REQ-021 Sub-module l1_lru_update SHALL be combinational: it takes the set's age vector and the accessed way and returns the new age vector. It is instantiated once.

Verification
REQ-022 Bench runs WAYS=2, INDEX_W=2, OFFSET_W=6 and covers these scenarios:
- Reset, then req_ready=0 for 4 cycles, then 1; all counters 0.
- Read 0x0000_0040 -> fill read to 0x40; resp_hit=0; repeat read -> resp_hit=1, 2 cycles after accept; hit_cnt=1, miss_cnt=1.
- Write 0x000, 0x100, 0x200 (same set 0) -> third access writes back 0x000, then fills 0x200; way chosen = LRU.
- Evict 0x100 while it is dirty -> writeback to 0x100, resp_hit=1; a later read of 0x100 misses.
- clear and req_valid in the same IDLE cycle -> request not accepted, 4-cycle CLEAR, counters 0, then the request is accepted.
- rst_n low during WB with l2_ready held 0 -> l2_valid falls the same cycle; no resp_valid.
